multicycle_ctrl: RTL and testbench

Multicycle control FSM for the group's RV32I subset: lw, sw, add, sub, xor, sll, addi, bne. It is the driving end of the ALU control interface. It issues the 3-bit ALU operation code, consumes the ALU Zero flag, and sequences the datapath enables: PC, IR, register file, memory address mux and result mux. It sits between the instruction register and the datapath, with one memory port under a ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/alu_op_decoder.sv | 23 ++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the RV32I-subset multicycle controller.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_NE  = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALUY   = 2'b10;

  // Dispatch out of DECODE; unsupported opcode/funct3 combinations trap.
  function automatic state_t decode_next(input logic [6:0] opcode, input logic [2:0] funct3);
    state_t s;
    s = S_TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) s = S_MEMADR;
      OP_R:              s = S_EXEC_R;
      OP_IMM:            if (funct3 == 3'b000) s = S_EXEC_I;
      OP_BRANCH:         if (funct3 == 3'b001) s = S_BRANCH;
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct7/funct3 to ALU operation, with a legality flag for unsupported pairs.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: alu_ctrl = ALU_ADD;
      {7'b0100000, 3'b000}: alu_ctrl = ALU_SUB;
      {7'b0000000, 3'b100}: alu_ctrl = ALU_XOR;
      {7'b0000000, 3'b001}: alu_ctrl = ALU_SLL;
      default:              legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences datapath enables and ALU control for lw/sw/R/addi/bne.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic [2:0]           alu_ctrl,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           result_src,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t               r_state, w_next;
  logic                 r_illegal;
  logic [INSTRET_W-1:0] r_instret;
  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [2:0]           w_rop;
  logic                 w_rlegal;
  logic                 w_retire;
  logic                 w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_reg_write;
  logic                 w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_unused = ^{instr[24:15], instr[11:7]};

  alu_op_decoder u_alu_dec (
    .funct7   (instr[31:25]),
    .funct3   (w_funct3),
    .alu_ctrl (w_rop),
    .legal    (w_rlegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE:   w_next = decode_next(w_opcode, w_funct3);
      S_MEMADR:   w_next = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = w_rlegal ? S_ALU_WB : S_TRAP;
      S_EXEC_I:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REGB;
    imm_src     = IMM_I;
    result_src  = RES_ALUOUT;
    iord        = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUY;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        imm_src   = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        iord       = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        result_src  = RES_MEM;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_REGA;
        alu_ctrl  = w_rop;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REGA;
        alu_ctrl   = ALU_NE;
        w_pc_write = ~alu_zero;
        w_retire   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst so an asynchronous reset kills them immediately.
  assign mem_read  = w_mem_read  & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign pc_write  = w_pc_write  & ~rst;
  assign reg_write = w_reg_write & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors checked by a monitor.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero, mem_ready;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic        iord, mem_read, mem_write, ir_write, pc_write, reg_write, illegal;
  logic [31:0] instret;

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  alu;
    logic [1:0]  sa, sb, imm, res;
    logic        iord, mr, mw, irw, pcw, rw, ill;
    logic [31:0] n;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } item_t;

  item_t       q[$];
  item_t       cur;
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_n    = 0;
  logic        exp_ill  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] alu, input logic [1:0] sa, sb, imm, res,
                              input logic io, mr, mw, irw, pcw, rw);
    exp_t e;
    e = '{alu: alu, sa: sa, sb: sb, imm: imm, res: res, iord: io, mr: mr, mw: mw,
          irw: irw, pcw: pcw, rw: rw, ill: exp_ill, n: exp_n};
    return e;
  endfunction

  // Monitor: the DUT presents a control vector every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      check(cur.tag,
            64'({alu_ctrl, alu_src_a, alu_src_b, imm_src, result_src, iord, mem_read,
                 mem_write, ir_write, pc_write, reg_write, illegal, instret}),
            64'(cur.e));
    end
  end

  task automatic step(input logic [31:0] ins, input logic z, input logic rdy,
                      input exp_t e, input string tag);
    @(posedge clk);
    #1;
    instr = ins; alu_zero = z; mem_ready = rdy;
    q.push_back('{e: e, tag: tag});
  endtask

  task automatic fetch(input logic [31:0] ins, input logic rdy);
    step(ins, 1'b0, rdy, mk(3'd0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 0, rdy, rdy, 0), "fetch");
  endtask

  task automatic decode(input logic [31:0] ins);
    step(ins, 1'b0, 1'b1, mk(3'd0, 2'b01, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0), "decode");
  endtask

  task automatic run_r(input logic [31:0] ins, input logic [2:0] op, input string tag);
    fetch(ins, 1'b1);
    decode(ins);
    step(ins, 1'b0, 1'b1, mk(op, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), {tag, "_exec"});
    step(ins, 1'b0, 1'b1, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1), {tag, "_wb"});
    exp_n++;
  endtask

  task automatic run_bne(input logic z);
    fetch(32'h00209463, 1'b1);
    decode(32'h00209463);
    step(32'h00209463, z, 1'b1, mk(3'd4, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ~z, 0),
         z ? "bne_not_taken" : "bne_taken");
    exp_n++;
  endtask

  task automatic trap_cycles(input logic [31:0] ins, input int k);
    for (int i = 0; i < k; i++)
      step(ins, 1'b0, 1'b1, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "trap");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_strobes", 64'({mem_read, mem_write, ir_write, pc_write, reg_write}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_n = 0;
    exp_ill = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
    #12;
    check("reset_strobes", 64'({mem_read, mem_write, ir_write, pc_write, reg_write}), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    check("reset_instret", 64'(instret), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_r(32'h002081B3, 3'd0, "add");
    run_r(32'h402081B3, 3'd1, "sub");
    run_r(32'h0020C1B3, 3'd2, "xor");
    run_r(32'h002091B3, 3'd3, "sll");
    run_bne(1'b0);
    run_bne(1'b1);

    // lw with one fetch wait and three memory wait cycles
    fetch(32'h0000A183, 1'b0);
    fetch(32'h0000A183, 1'b1);
    decode(32'h0000A183);
    step(32'h0000A183, 0, 1, mk(3'd0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "lw_memadr");
    for (int i = 0; i < 3; i++)
      step(32'h0000A183, 0, 0, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0), "lw_wait");
    step(32'h0000A183, 0, 1, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0), "lw_read");
    step(32'h0000A183, 0, 1, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1), "lw_memwb");
    exp_n++;

    // sw completing normally
    fetch(32'h0020A023, 1'b1);
    decode(32'h0020A023);
    step(32'h0020A023, 0, 1, mk(3'd0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "sw_memadr");
    step(32'h0020A023, 0, 1, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0), "sw_write");
    exp_n++;
    fetch(32'h0020A023, 1'b1);
    decode(32'h0020A023);
    step(32'h0020A023, 0, 1, mk(3'd0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "sw2_memadr");
    step(32'h0020A023, 0, 0, mk(3'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0), "sw2_wait");

    // async reset in the completing MEMWRITE cycle aborts the store
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("abort_pre_mem_write", 64'(mem_write), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_mem_write", 64'(mem_write), 64'd0);
    check("abort_instret", 64'(instret), 64'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_n = 0;

    // illegal opcode traps, flag is sticky
    run_r(32'h002081B3, 3'd0, "add2");
    fetch(32'hFFFFFFFF, 1'b1);
    decode(32'hFFFFFFFF);
    exp_ill = 1;
    trap_cycles(32'hFFFFFFFF, 20);
    do_reset();

    // R-type with unsupported funct7/funct3 pair traps from EXEC_R without retiring
    fetch(32'h4020C1B3, 1'b1);
    decode(32'h4020C1B3);
    step(32'h4020C1B3, 0, 1, mk(3'd0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "rbad_exec");
    exp_ill = 1;
    trap_cycles(32'h4020C1B3, 5);
    do_reset();

    run_r(32'h002091B3, 3'd3, "sll_after_reset");
    fetch(32'h00000000, 1'b0);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
